// File: rtl/accum_zone_ctrl_pkg.sv
// Shared sizing defaults and write-stage payload for the accumulate zone controller.
// Pure declarations; no timing or flow-control behaviour of its own.
package accum_pkg;

  localparam int ACC_NUM_BANKS  = 4;
  localparam int ACC_DATA_WIDTH = 64;
  localparam int ACC_ADDR_WIDTH = 9;
  localparam int ACC_ZONE_WIDTH = 2;

  typedef struct packed {
    logic [ACC_NUM_BANKS-1:0]                     mask;
    logic [ACC_ADDR_WIDTH-1:0]                    addr;
    logic [ACC_NUM_BANKS-1:0][ACC_DATA_WIDTH-1:0] data;
  } wr_pay_t;

  typedef enum logic {
    PRIO_RD = 1'b0,
    PRIO_WR = 1'b1
  } prio_e;

endpackage

// File: rtl/accum_zone_ctrl_if.sv
// Command and data bundles between the zone router and the accumulate controller.
// Valid/ready on both command channels; read return is valid-only (no backpressure).
interface Accum_Cmd_If
  import accum_pkg::*;
#(
  parameter int ZONE_WIDTH = ACC_ZONE_WIDTH,
  parameter int ADDR_WIDTH = ACC_ADDR_WIDTH,
  parameter int NUM_BANKS  = ACC_NUM_BANKS
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ZONE_WIDTH-1:0] wr_zone_id;
  logic                  accum_en;
  logic [NUM_BANKS-1:0]  wr_mask;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ZONE_WIDTH-1:0] rd_zone_id;
  logic [NUM_BANKS-1:0]  rd_mask;
  logic [ADDR_WIDTH-1:0] rd_addr;

  modport Master (
    output wr_valid, wr_zone_id, accum_en, wr_mask, wr_addr,
    output rd_valid, rd_zone_id, rd_mask, rd_addr,
    input  wr_ready, rd_ready
  );

  modport Slave (
    input  wr_valid, wr_zone_id, accum_en, wr_mask, wr_addr,
    input  rd_valid, rd_zone_id, rd_mask, rd_addr,
    output wr_ready, rd_ready
  );
endinterface

interface Accum_Data_If
  import accum_pkg::*;
#(
  parameter int NUM_BANKS  = ACC_NUM_BANKS,
  parameter int DATA_WIDTH = ACC_DATA_WIDTH
);
  logic                                 wvalid;
  logic                                 wready;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] wdata;
  logic                                 rvalid;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rdata;

  modport Master (
    output wvalid, wdata,
    input  wready, rvalid, rdata
  );

  modport Slave (
    input  wvalid, wdata,
    output wready, rvalid, rdata
  );
endinterface

// File: rtl/accum_zone_ctrl_bank.sv
// One bank word column: 1W1R synchronous SRAM, 1-cycle registered read.
// Read-during-write to the same address returns the old word; no backpressure.
module Accum_Bank
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = ACC_DATA_WIDTH,
  parameter int ADDR_WIDTH = ACC_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/accum_zone_ctrl.sv
// Zone accumulate controller: masked plain/accumulate writes (commit 1 edge after accept), reads return 2 edges after accept.
// Accum writes and reads share the bank read port; a toggling priority bit picks the winner on conflict, plain writes never stall.
module accum_zone_ctrl
  import accum_pkg::*;
#(
  parameter int ZONE_ID    = 0,
  parameter int ZONE_WIDTH = ACC_ZONE_WIDTH,
  parameter int NUM_BANKS  = ACC_NUM_BANKS,
  parameter int DATA_WIDTH = ACC_DATA_WIDTH,
  parameter int ADDR_WIDTH = ACC_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rstn,
  Accum_Cmd_If.Slave  s_cmd,
  Accum_Data_If.Slave s_data
);

  typedef logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] row_t;

  logic                  conflict;
  logic                  rd_rdy;
  logic                  wr_rdy;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  port_wr;
  logic                  port_re;
  logic [ADDR_WIDTH-1:0] port_addr;

  prio_e                 prio_q, prio_d;
  logic                  wr_s1_vld_q, wr_s1_vld_d;
  logic                  wr_s1_acc_q, wr_s1_acc_d;
  wr_pay_t               wr_s1_q, wr_s1_d;
  wr_pay_t               commit;
  logic                  rd_s1_vld_q, rd_s1_vld_d;
  logic [NUM_BANKS-1:0]  rd_s1_mask_q, rd_s1_mask_d;
  logic [NUM_BANKS-1:0]  fwd_mask_q, fwd_mask_d;
  row_t                  fwd_dat_q, fwd_dat_d;
  logic                  rvalid_q, rvalid_d;
  row_t                  rdata_q, rdata_d;
  logic [NUM_BANKS-1:0]  bank_we;
  row_t                  bank_rdat;
  row_t                  old_dat;
  logic                  unused_zone;

  // Zone ids are already resolved by the router.
  assign unused_zone = ^{s_cmd.wr_zone_id, s_cmd.rd_zone_id, (ZONE_ID != 0), (ZONE_WIDTH != 0)};

  always_comb begin
    conflict  = s_cmd.rd_valid && s_cmd.wr_valid && s_data.wvalid && s_cmd.accum_en;
    rd_rdy    = !conflict || (prio_q == PRIO_RD);
    wr_rdy    = !conflict || (prio_q == PRIO_WR);
    wr_acc    = s_cmd.wr_valid && s_data.wvalid && wr_rdy;
    rd_acc    = s_cmd.rd_valid && rd_rdy;
    port_wr   = wr_acc && s_cmd.accum_en;
    port_re   = port_wr || rd_acc;
    port_addr = port_wr ? s_cmd.wr_addr : s_cmd.rd_addr;
  end

  assign s_cmd.wr_ready = wr_rdy;
  assign s_cmd.rd_ready = rd_rdy;
  assign s_data.wready  = wr_rdy;
  assign s_data.rvalid  = rvalid_q;
  assign s_data.rdata   = rdata_q;

  // Old word: the value committed on the launch edge wins over the SRAM's pre-write data.
  always_comb begin
    old_dat = bank_rdat;
    commit  = wr_s1_q;
    bank_we = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (fwd_mask_q[b]) old_dat[b] = fwd_dat_q[b];
      commit.data[b] = wr_s1_acc_q ? old_dat[b] + wr_s1_q.data[b] : wr_s1_q.data[b];
      bank_we[b]     = wr_s1_vld_q && wr_s1_q.mask[b];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    Accum_Bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (commit.addr),
      .wdata (commit.data[b]),
      .re    (port_re),
      .raddr (port_addr),
      .rdata (bank_rdat[b])
    );
  end

  always_comb begin
    prio_d = prio_q;
    if (conflict) prio_d = (prio_q == PRIO_RD) ? PRIO_WR : PRIO_RD;

    wr_s1_vld_d = wr_acc;
    wr_s1_acc_d = wr_s1_acc_q;
    wr_s1_d     = wr_s1_q;
    if (wr_acc) begin
      wr_s1_acc_d  = s_cmd.accum_en;
      wr_s1_d.mask = s_cmd.wr_mask;
      wr_s1_d.addr = s_cmd.wr_addr;
      wr_s1_d.data = s_data.wdata;
    end

    rd_s1_vld_d  = rd_acc;
    rd_s1_mask_d = rd_acc ? s_cmd.rd_mask : rd_s1_mask_q;

    fwd_dat_d  = commit.data;
    fwd_mask_d = '0;
    if (port_re && wr_s1_vld_q && (commit.addr == port_addr)) fwd_mask_d = commit.mask;

    rvalid_d = rd_s1_vld_q;
    rdata_d  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_s1_vld_q && rd_s1_mask_q[b]) rdata_d[b] = old_dat[b];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_q       <= PRIO_RD;
      wr_s1_vld_q  <= 1'b0;
      wr_s1_acc_q  <= 1'b0;
      wr_s1_q      <= '0;
      rd_s1_vld_q  <= 1'b0;
      rd_s1_mask_q <= '0;
      fwd_mask_q   <= '0;
      fwd_dat_q    <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      prio_q       <= prio_d;
      wr_s1_vld_q  <= wr_s1_vld_d;
      wr_s1_acc_q  <= wr_s1_acc_d;
      wr_s1_q      <= wr_s1_d;
      rd_s1_vld_q  <= rd_s1_vld_d;
      rd_s1_mask_q <= rd_s1_mask_d;
      fwd_mask_q   <= fwd_mask_d;
      fwd_dat_q    <= fwd_dat_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_accum_zone_ctrl.sv
// Directed + random bench for accum_zone_ctrl against a transaction-level memory model.
module tb_accum_zone_ctrl;
  import accum_pkg::*;

  localparam int NB = 4;
  localparam int DW = 64;
  localparam int AW = 9;

  typedef logic [NB-1:0][DW-1:0] row_t;
  typedef struct {
    int   due;
    row_t dat;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  Accum_Cmd_If  #(.ZONE_WIDTH(2), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) cmd_if ();
  Accum_Data_If #(.NUM_BANKS(NB), .DATA_WIDTH(DW))                 dat_if ();

  accum_zone_ctrl #(
    .ZONE_ID    (0),
    .ZONE_WIDTH (2),
    .NUM_BANKS  (NB),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_cmd  (cmd_if),
    .s_data (dat_if)
  );

  // Model: memory updated at acceptance, reads see all earlier-accepted writes.
  row_t    mem_m [16];
  row_t    pre   [16];
  bit      prio_m;
  rd_exp_t rq [$];
  bit      pend_w;
  int      pend_a;
  row_t    pend_old;

  int      checks = 0;
  int      errors = 0;
  row_t    last_rdata;
  bit      last_rrdy;
  bit      last_wrdy;
  logic [3:0] g_r;
  logic [3:0] g_w;

  function automatic row_t row4(input logic [63:0] b0, input logic [63:0] b1,
                                input logic [63:0] b2, input logic [63:0] b3);
    row4 = {b3, b2, b1, b0};
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int b = 0; b < NB; b++) r[b] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    cmd_if.wr_valid   = 1'b0;
    cmd_if.wr_zone_id = '0;
    cmd_if.accum_en   = 1'b0;
    cmd_if.wr_mask    = '0;
    cmd_if.wr_addr    = '0;
    cmd_if.rd_valid   = 1'b0;
    cmd_if.rd_zone_id = '0;
    cmd_if.rd_mask    = '0;
    cmd_if.rd_addr    = '0;
    dat_if.wvalid     = 1'b0;
    dat_if.wdata      = '0;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic do_cycle(input bit rv, input int ra, input logic [3:0] rm,
                          input bit wv, input bit dv, input bit acc,
                          input int wa, input logic [3:0] wm, input row_t wd);
    bit      conf, er, ew, wacc, racc, exp_v;
    row_t    exp_r, rexp;
    rd_exp_t e;
    cmd_if.rd_valid   = rv;
    cmd_if.rd_addr    = ra[AW-1:0];
    cmd_if.rd_mask    = rm;
    cmd_if.rd_zone_id = 2'($urandom);
    cmd_if.wr_valid   = wv;
    cmd_if.accum_en   = acc;
    cmd_if.wr_addr    = wa[AW-1:0];
    cmd_if.wr_mask    = wm;
    cmd_if.wr_zone_id = 2'($urandom);
    dat_if.wvalid     = dv;
    dat_if.wdata      = wd;
    @(negedge clk);
    conf  = rv && wv && dv && acc;
    er    = !conf || !prio_m;
    ew    = !conf || prio_m;
    exp_v = 1'b0;
    exp_r = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_v = 1'b1;
      exp_r = rq[0].dat;
      void'(rq.pop_front());
    end
    last_rrdy = cmd_if.rd_ready;
    last_wrdy = cmd_if.wr_ready;
    chk("rd_ready", cmd_if.rd_ready, er);
    chk("wr_ready", cmd_if.wr_ready, ew);
    chk("wready", dat_if.wready, ew);
    chk("rvalid", dat_if.rvalid, exp_v);
    chk("rdata", dat_if.rdata, exp_r);
    if (dat_if.rvalid) last_rdata = dat_if.rdata;
    wacc = wv && dv && ew;
    racc = rv && er;
    if (racc) begin
      rexp = '0;
      for (int b = 0; b < NB; b++) if (rm[b]) rexp[b] = mem_m[ra][b];
      e.due = cyc + 2;
      e.dat = rexp;
      rq.push_back(e);
    end
    pend_w = wacc;
    if (wacc) begin
      pend_a   = wa;
      pend_old = mem_m[wa];
      for (int b = 0; b < NB; b++)
        if (wm[b]) mem_m[wa][b] = acc ? mem_m[wa][b] + wd[b] : wd[b];
    end
    if (conf) prio_m = !prio_m;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, '0);
  endtask

  // Reset drops the uncommitted write and any read still in flight.
  task automatic do_reset();
    rstn = 1'b0;
    if (pend_w) mem_m[pend_a] = pend_old;
    pend_w = 1'b0;
    rq.delete();
    prio_m = 1'b0;
    set_idle();
    #1;
    chk("rst_rvalid", dat_if.rvalid, 1'b0);
    chk("rst_rdata", dat_if.rdata, '0);
    cmd_if.rd_valid = 1'b1;
    cmd_if.wr_valid = 1'b1;
    cmd_if.accum_en = 1'b1;
    dat_if.wvalid   = 1'b1;
    #1;
    chk("rst_prio_rd_ready", cmd_if.rd_ready, 1'b1);
    chk("rst_prio_wr_ready", cmd_if.wr_ready, 1'b0);
    set_idle();
    @(posedge clk);
    #1;
    chk("rst_rvalid_hold", dat_if.rvalid, 1'b0);
    rstn = 1'b1;
  endtask

  initial begin
    rstn   = 1'b1;
    pend_w = 1'b0;
    prio_m = 1'b0;
    set_idle();
    #1;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      pre[i] = rand_row();
      do_cycle(0, 0, 4'h0, 1, 1, 0, i, 4'hF, pre[i]);
    end
    idle(1);

    // Plain write then read back.
    last_rdata = '0;
    do_cycle(0, 0, 4'h0, 1, 1, 0, 5, 4'hF, row4(1, 2, 3, 4));
    do_cycle(1, 5, 4'hF, 0, 0, 0, 0, 4'h0, '0);
    idle(3);
    chk("plain_rw", last_rdata, row4(1, 2, 3, 4));

    // Back-to-back accumulates on one bank.
    last_rdata = '0;
    do_cycle(0, 0, 4'h0, 1, 1, 0, 7, 4'hF, row4(10, 10, 10, 10));
    do_cycle(0, 0, 4'h0, 1, 1, 1, 7, 4'h1, row4(5, 0, 0, 0));
    do_cycle(0, 0, 4'h0, 1, 1, 1, 7, 4'h1, row4(5, 0, 0, 0));
    do_cycle(1, 7, 4'hF, 0, 0, 0, 0, 4'h0, '0);
    idle(3);
    chk("accum_b2b", last_rdata, row4(20, 10, 10, 10));

    // Accumulate wraps modulo 2^64.
    last_rdata = '0;
    do_cycle(0, 0, 4'h0, 1, 1, 0, 3, 4'h1, row4(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0));
    idle(1);
    do_cycle(0, 0, 4'h0, 1, 1, 1, 3, 4'h1, row4(2, 0, 0, 0));
    idle(1);
    do_cycle(1, 3, 4'hF, 0, 0, 0, 0, 4'h0, '0);
    idle(3);
    chk("accum_wrap", last_rdata[0], 64'd1);

    // Conflict arbitration from reset, then plain write alongside a read.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_cycle(1, 7, 4'hF, 1, 1, 1, 6, 4'hF, row4(1, 1, 1, 1));
      g_r[i] = last_rrdy;
      g_w[i] = last_wrdy;
    end
    chk("grant_rd_seq", g_r, 4'b0101);
    chk("grant_wr_seq", g_w, 4'b1010);
    idle(3);
    last_rdata = '0;
    do_cycle(1, 5, 4'hF, 1, 1, 0, 5, 4'hF, row4(9, 9, 9, 9));
    chk("plain_no_stall_rd", last_rrdy, 1'b1);
    chk("plain_no_stall_wr", last_wrdy, 1'b1);
    idle(3);
    chk("same_edge_prewrite", last_rdata, row4(1, 2, 3, 4));
    last_rdata = '0;
    do_cycle(1, 5, 4'hF, 0, 0, 0, 0, 4'h0, '0);
    idle(3);
    chk("same_edge_postwrite", last_rdata, row4(9, 9, 9, 9));

    // Masked read, then reset right after a write accept.
    last_rdata = '1;
    do_cycle(1, 9, 4'b0101, 0, 0, 0, 0, 4'h0, '0);
    idle(3);
    chk("mask_bank1_zero", last_rdata[1], 64'd0);
    chk("mask_bank3_zero", last_rdata[3], 64'd0);
    do_cycle(1, 9, 4'hF, 1, 1, 1, 11, 4'hF, row4(3, 3, 3, 3));
    do_cycle(1, 5, 4'hF, 1, 1, 0, 10, 4'hF, row4(7, 7, 7, 7));
    do_reset();
    idle(3);
    last_rdata = '0;
    do_cycle(1, 10, 4'hF, 0, 0, 0, 0, 4'h0, '0);
    idle(3);
    chk("reset_drops_write", last_rdata, pre[10]);

    for (int i = 0; i < 600; i++) begin
      row_t wd;
      wd = rand_row();
      if ($urandom_range(0, 7) == 0) wd[$urandom_range(0, 3)] = '1;
      do_cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 3), 4'($urandom),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
               bit'($urandom_range(0, 1)), $urandom_range(0, 3), 4'($urandom), wd);
    end
    idle(4);
    chk("read_queue_drained", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accum_zone_ctrl.md
ACCUM_ZONE_CTRL -- requirements
Module: accum_zone_ctrl

Interface
REQ-001 SHALL have parameter ZONE_ID, default 0: zone index this instance serves.
REQ-002 SHALL have parameter ZONE_WIDTH, default 2: zone-id field width.
REQ-003 SHALL have parameter NUM_BANKS, default 4: banks per row.
REQ-004 SHALL have parameter DATA_WIDTH, default 64: bits per bank word.
REQ-005 SHALL have parameter ADDR_WIDTH, default 9: row address width; depth 2^ADDR_WIDTH.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port s_cmd  Accum_Cmd_If.Slave  -  wr_valid/wr_ready/wr_zone_id/accum_en/wr_mask/wr_addr, rd_valid/rd_ready/rd_zone_id/rd_mask/rd_addr.
REQ-009 SHALL have port s_data  Accum_Data_If.Slave  -  wvalid/wready/wdata[NUM_BANKS][DATA_WIDTH], rvalid/rdata[NUM_BANKS][DATA_WIDTH].

Function
REQ-010 SHALL accept a write at a rising edge where wr_valid && wvalid && wr_ready; wready SHALL equal wr_ready.
REQ-011 SHALL accept a read at a rising edge where rd_valid && rd_ready.
REQ-012 SHALL ignore wr_zone_id/rd_zone_id; the upstream router guarantees routing.
REQ-013 Per masked bank b: new = accum_en ? mem[addr][b] + wdata[b] : wdata[b], truncated mod 2^DATA_WIDTH; unmasked banks unchanged.
REQ-014 Write pipeline: acceptance at edge E0 launches the bank read; sum is formed combinationally in cycle E0..E1; write commits at E1 (one stage, wr_s1 register).
REQ-015 If the write accepted at E0 targets the same addr as the wr_s1 write committing at E0, the old value for overlapping masked banks SHALL be forwarded from wr_s1 (back-to-back accumulates are exact).
REQ-016 Read accepted at E0 SHALL drive rvalid=1 and rdata for the cycle following E1 (2-edge latency, registered); rvalid SHALL be 1 for exactly one cycle per read.
REQ-017 rdata of unmasked banks SHALL be 0; rvalid=0 implies rdata=0.
REQ-018 Read SHALL forward from wr_s1 under the REQ-015 rule; a read accepted at the same edge as a write returns pre-write data.
REQ-019 Bank read port is shared; conflict = rd_valid && wr_valid && wvalid && accum_en.
REQ-020 Without conflict: rd_ready=1, wr_ready=1; plain writes (accum_en=0) are never blocked.
REQ-021 On conflict a 1-bit prio register selects the winner (0=read, 1=write); loser's ready=0; prio toggles only on conflict edges.
REQ-022 Full-throughput: one read and one write accepted per cycle when not conflicting.

Reset
REQ-023 While rstn=0: wr_s1 valid=0, rvalid=0, rdata=0, prio=0; readies combinational per REQ-020/021.
REQ-024 Reset asserted mid-operation SHALL cancel an uncommitted wr_s1 write and any pending read return; bank contents are not reset.

Structure
REQ-025 Package accum_pkg SHALL hold default NUM_BANKS/DATA_WIDTH/ADDR_WIDTH/ZONE_WIDTH and the write-stage payload typedef (mask, addr, sum data).
REQ-026 Sub-module Accum_Bank: 1W1R synchronous SRAM, one DATA_WIDTH word, 1-cycle read, read-during-write returns old data; NUM_BANKS instances.

Verification
REQ-027 Plain write addr 5, mask 4'hF, data {1,2,3,4}; read addr 5 mask 4'hF -> rvalid 2 edges after accept, rdata {1,2,3,4}.
REQ-028 Preload addr 7 = all 10; accum writes addr 7 mask 4'h1 data 5 on two consecutive edges; read -> bank0=20, banks1-3=10.
REQ-029 Preload addr 3 bank0 = 2^64-1; accum +2 -> bank0 reads 1 (wrap).
REQ-030 rd_valid and accum wr_valid both held high 4 cycles from reset -> grants read, write, read, write; plain write with rd_valid -> both accepted same edge.
REQ-031 Read addr 9 mask 4'b0101 -> rdata banks 1,3 = 0; rstn pulse low the cycle after a write accept -> rvalid=0, prio=0, write absent on later read.
